// File: rtl/twi_pkg.sv
// Shared encodings for the twi_core register port and the poll arbiter FSM.
package twi_pkg;

   localparam logic [5:0] I2CR_ADDR = 6'h00;
   localparam logic [5:0] I2WD_ADDR = 6'h04;

   localparam int CMD_START = 0;
   localparam int CMD_STOP  = 1;
   localparam int CMD_WR    = 2;
   localparam int CMD_RD    = 3;
   localparam int CMD_NACK  = 4;

   localparam int ST_BUSY   = 7;
   localparam int ST_RXNACK = 6;

   localparam int STEP_W = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CPU,
      S_LD_DATA,
      S_LD_CMD,
      S_GUARD,
      S_WAIT,
      S_CHECK,
      S_DONE,
      S_ABORT
   } state_t;

   function automatic logic [7:0] step_cmd(input logic [STEP_W-1:0] s);
      logic [7:0] c;
      c = 8'h00;
      if (s == 3'd0 || s == 3'd2) begin
         c[CMD_START] = 1'b1;
         c[CMD_WR]    = 1'b1;
      end else if (s == 3'd1) begin
         c[CMD_WR] = 1'b1;
      end else if (s == 3'd3) begin
         c[CMD_RD] = 1'b1;
      end else begin
         c[CMD_RD]   = 1'b1;
         c[CMD_NACK] = 1'b1;
         c[CMD_STOP] = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/twi_poll_sched.sv
// Poll scheduler: counts 1 s ticks and raises a pending request each period.
module twi_poll_sched (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       tick_1s,
   input  logic       poll_en,
   input  logic [5:0] poll_period,
   input  logic       pend_clr,
   output logic       pending
);

   logic [5:0] cnt;
   logic [6:0] per_eff;
   logic       hit;

   assign per_eff = (poll_period == 6'd0) ? 7'd1 : {1'b0, poll_period};
   assign hit     = tick_1s && (({1'b0, cnt} + 7'd1) >= per_eff);

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         cnt     <= 6'd0;
         pending <= 1'b0;
      end else if (!poll_en) begin
         cnt     <= 6'd0;
         pending <= 1'b0;
      end else begin
         if (tick_1s)
            cnt <= hit ? 6'd0 : cnt + 6'd1;
         // a fresh request outranks the clear from a finishing poll
         if (hit)
            pending <= 1'b1;
         else if (pend_clr)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/twi_poll_arb.sv
// Arbitrates the twi_core register port between CPU writes and a periodic
// hardware poller that reads a 16-bit register from one I2C slave.
module twi_poll_arb
   import twi_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = 7'h48,
   parameter logic [7:0]  REG_PTR  = 8'h00,
   parameter logic [19:0] TIMEOUT  = 20'd1000000,
   parameter int          GUARD    = 2
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        cpu_lock,
   output logic        cpu_gnt,
   input  logic        cpu_wr,
   input  logic [5:0]  cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        core_wr,
   output logic [7:0]  core_addr,
   output logic [7:0]  core_wdata,
   input  logic [7:0]  core_i2cr,
   input  logic [7:0]  core_i2rd,
   input  logic        tick_1s,
   input  logic        poll_en,
   input  logic [5:0]  poll_period,
   input  logic [15:0] temp_hi,
   output logic [15:0] temp_val,
   output logic        temp_vld,
   output logic        temp_alert,
   output logic        poll_err,
   input  logic        err_clr
);

   localparam logic [3:0] GUARD_M1 = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;

   state_t              state, state_nx;
   logic [STEP_W-1:0]   step;
   logic [3:0]          gcnt;
   logic [19:0]         tcnt;
   logic                aborting;
   logic [7:0]          msb, lsb;
   logic                pending, pend_clr;
   logic                busy, rxnack, tmo, nack_fail;
   logic [7:0]          step_data;

   assign busy      = core_i2cr[ST_BUSY];
   assign rxnack    = core_i2cr[ST_RXNACK];
   assign tmo       = tcnt >= (TIMEOUT - 20'd1);
   assign nack_fail = (step <= 3'd2) && rxnack;
   assign cpu_gnt   = (state == S_CPU);

   assign step_data = (step == 3'd0) ? {DEV_ADDR, 1'b0} :
                      (step == 3'd1) ? REG_PTR :
                                       {DEV_ADDR, 1'b1};

   twi_poll_sched u_sched (
      .CLK_I       (CLK_I),
      .RST_I       (RST_I),
      .tick_1s     (tick_1s),
      .poll_en     (poll_en),
      .poll_period (poll_period),
      .pend_clr    (pend_clr),
      .pending     (pending)
   );

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      core_wr    = 1'b0;
      core_addr  = 8'h00;
      core_wdata = 8'h00;
      pend_clr   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cpu_lock)
               state_nx = S_CPU;
            else if (pending)
               state_nx = S_LD_DATA;
         end
         S_CPU: begin
            core_wr    = cpu_wr;
            core_addr  = {2'b00, cpu_addr};
            core_wdata = cpu_wdata;
            if (!cpu_lock)
               state_nx = S_IDLE;
         end
         S_LD_DATA: begin
            core_wr    = 1'b1;
            core_addr  = {2'b00, I2WD_ADDR};
            core_wdata = step_data;
            state_nx   = S_LD_CMD;
         end
         S_LD_CMD: begin
            core_wr    = 1'b1;
            core_addr  = {2'b00, I2CR_ADDR};
            core_wdata = step_cmd(step);
            state_nx   = S_GUARD;
         end
         S_GUARD: begin
            if (gcnt >= GUARD_M1)
               state_nx = S_WAIT;
         end
         S_WAIT: begin
            // the STOP issued by an abort is waited out without a timeout
            if (!busy)
               state_nx = aborting ? S_IDLE : S_CHECK;
            else if (!aborting && tmo)
               state_nx = S_ABORT;
         end
         S_CHECK: begin
            if (nack_fail)
               state_nx = S_ABORT;
            else if (step == 3'd4)
               state_nx = S_DONE;
            else if (step >= 3'd2)
               state_nx = S_LD_CMD;
            else
               state_nx = S_LD_DATA;
         end
         S_DONE: begin
            pend_clr = 1'b1;
            state_nx = S_IDLE;
         end
         S_ABORT: begin
            core_wr    = 1'b1;
            core_addr  = {2'b00, I2CR_ADDR};
            core_wdata = 8'h01 << CMD_STOP;
            pend_clr   = 1'b1;
            state_nx   = S_GUARD;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         step       <= '0;
         gcnt       <= 4'd0;
         tcnt       <= 20'd0;
         aborting   <= 1'b0;
         msb        <= 8'h00;
         lsb        <= 8'h00;
         temp_val   <= 16'h0000;
         temp_vld   <= 1'b0;
         temp_alert <= 1'b0;
         poll_err   <= 1'b0;
      end else begin
         if (state == S_IDLE && !cpu_lock && pending) begin
            step     <= '0;
            aborting <= 1'b0;
         end
         if (state == S_LD_CMD || state == S_ABORT)
            gcnt <= 4'd0;
         else if (state == S_GUARD)
            gcnt <= gcnt + 4'd1;
         if (state == S_GUARD)
            tcnt <= 20'd0;
         else if (state == S_WAIT)
            tcnt <= tcnt + 20'd1;
         if (state == S_CHECK && !nack_fail) begin
            if (step == 3'd3)
               msb <= core_i2rd;
            if (step == 3'd4)
               lsb <= core_i2rd;
            step <= step + 3'd1;
         end
         if (state == S_DONE) begin
            temp_val   <= {msb, lsb};
            temp_vld   <= 1'b1;
            temp_alert <= ({msb, lsb} >= temp_hi);
         end
         if (state == S_ABORT) begin
            aborting <= 1'b1;
            poll_err <= 1'b1;
         end else if (err_clr) begin
            poll_err <= 1'b0;
         end
      end
   end

endmodule
